button_debouncer: RTL

- N-channel synchronizer and debouncer for raw board inputs (push buttons, switches).
- Sits directly upstream of the combinational gate stage: out[0] and out[1] drive the a and b inputs of the Or gate in the board-level demo.
- Each channel also produces single-cycle rise and fall pulses for downstream sequential logic.

---
 rtl/button_debouncer.sv | 99 +++++++++
 1 files changed

// File: rtl/button_debouncer.sv
// N-channel 2-FF synchronizer and counter-based debouncer. Each channel also
// emits registered one-cycle rise/fall pulses when its debounced level changes.
module button_debouncer #(
    parameter int N             = 2,
    parameter int CNT_WIDTH     = 16,
    parameter int STABLE_CYCLES = 50000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] in,
    output logic [N-1:0] out,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall
);

    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    // Terminal count: the window closes on the STABLE_CYCLES-th mismatching sample.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic [N-1:0] sync1_r;
    logic [N-1:0] sync2_r;

    // Two-flop synchronizer for the raw asynchronous inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= {N{1'b0}};
            sync2_r <= {N{1'b0}};
        end else begin
            sync1_r <= in;
            sync2_r <= sync1_r;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        state_t               state_r;
        logic [CNT_WIDTH-1:0] cnt_r;
        logic                 out_r;
        logic                 rise_r;
        logic                 fall_r;
        logic                 mismatch_s;

        assign mismatch_s = sync2_r[i] ^ out_r;

        // Per-channel debounce FSM; any matching sample in CHECK restarts the window.
        always_ff @(posedge clk) begin
            if (reset) begin
                state_r <= STABLE;
                cnt_r   <= CNT_ZERO;
                out_r   <= 1'b0;
                rise_r  <= 1'b0;
                fall_r  <= 1'b0;
            end else begin
                rise_r <= 1'b0;
                fall_r <= 1'b0;
                case (state_r)
                    STABLE: begin
                        if (mismatch_s) begin
                            state_r <= CHECK;
                            cnt_r   <= CNT_ONE;
                        end else begin
                            state_r <= STABLE;
                            cnt_r   <= CNT_ZERO;
                        end
                    end
                    CHECK: begin
                        if (!mismatch_s) begin
                            state_r <= STABLE;
                            cnt_r   <= CNT_ZERO;
                        end else if (cnt_r == CNT_LAST) begin
                            state_r <= STABLE;
                            cnt_r   <= CNT_ZERO;
                            out_r   <= sync2_r[i];
                            rise_r  <= sync2_r[i];
                            fall_r  <= ~sync2_r[i];
                        end else begin
                            state_r <= CHECK;
                            cnt_r   <= cnt_r + CNT_ONE;
                        end
                    end
                    default: begin
                        state_r <= STABLE;
                        cnt_r   <= CNT_ZERO;
                    end
                endcase
            end
        end

        assign out[i]  = out_r;
        assign rise[i] = rise_r;
        assign fall[i] = fall_r;
    end

endmodule
